// File: rtl/decode_queue.sv
// decode_queue: elastic FIFO between decode and rename, flushed in one cycle on mispredict
module decode_queue #(
    parameter int WIDTH_P       = 32,
    parameter int DEPTH_P       = 8,
    parameter int ALMOST_FULL_P = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       mispredict_i,
    input  logic [WIDTH_P-1:0]         decoded_i,
    input  logic                       decoded_v_i,
    output logic                       queue_decode_ready_o,
    output logic [WIDTH_P-1:0]         queue_rename_o,
    output logic                       queue_rename_v_o,
    input  logic                       rename_queue_ready_i,
    output logic [$clog2(DEPTH_P):0]   count_o,
    output logic                       almost_full_o
);
    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    logic               push, pop;
    // Ready looks only at registered occupancy, so a full queue refuses a push even while popping.
    assign queue_decode_ready_o = count != CNT_W'(DEPTH_P);
    assign queue_rename_v_o     = count != '0;
    assign queue_rename_o       = mem[head];
    assign count_o              = count;
    assign almost_full_o        = count >= CNT_W'(ALMOST_FULL_P);
    assign push = decoded_v_i & queue_decode_ready_o & ~mispredict_i;
    assign pop  = queue_rename_v_o & rename_queue_ready_i & ~mispredict_i;
    always_ff @(posedge clk_i) begin
        if (reset_i || mispredict_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= pop ? head + PTR_W'(1) : head;
            tail  <= push ? tail + PTR_W'(1) : tail;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[tail] <= decoded_i;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Elastic FIFO between the front-end decoder and the back-end rename stage.
- Buffers decoded instructions so decode can run ahead of rename.
- Decouples the decoder's valid/ready handshake from rename's.
- Flushed in one cycle on a back-end mispredict so no wrong-path instruction reaches rename after redirect.

Parameters:
- WIDTH_P, DECODED_INSTRUCTION_WIDTH: width of one decoded instruction word.
- DEPTH_P, 8: number of entries; must be a power of two, minimum 2.
- ALMOST_FULL_P, 6: occupancy at or above which almost_full_o asserts; range 1..DEPTH_P.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- mispredict_i  input  1  flush request from the back end, driven by be_fe_mispredict_o.
- decoded_i  input  WIDTH_P  instruction from the decoder.
- decoded_v_i  input  1  decoder valid.
- queue_decode_ready_o  output  1  queue can accept an entry this cycle.
- queue_rename_o  output  WIDTH_P  head entry presented to rename.
- queue_rename_v_o  output  1  head entry valid.
- rename_queue_ready_i  input  1  rename accepts the head this cycle.
- count_o  output  $clog2(DEPTH_P)+1  current occupancy.
- almost_full_o  output  1  count_o >= ALMOST_FULL_P.

Behaviour:
- Storage: circular buffer of DEPTH_P entries, addressed by a head pointer and a tail pointer of $clog2(DEPTH_P) bits each, plus an occupancy counter. Pointers wrap modulo DEPTH_P with no special case.
- Push: occurs when decoded_v_i & queue_decode_ready_o & !mispredict_i. decoded_i is written at tail, tail increments.
- Pop: occurs when queue_rename_v_o & rename_queue_ready_i & !mispredict_i. Head increments.
- queue_decode_ready_o = (count != DEPTH_P).
  - It depends on registered state only; it never depends on rename_queue_ready_i.
  - When full, no push is accepted even if a pop happens in the same cycle.
- queue_rename_v_o = (count != 0). queue_rename_o = entry at head (combinational read of registered storage).
- Latency:
  - An entry pushed in cycle N is visible at the output in cycle N+1.
  - There is no same-cycle bypass from input to output.
- Simultaneous push and pop (count neither 0 nor DEPTH_P): both pointers advance and count is unchanged.
- Empty:
  - queue_rename_v_o = 0.
  - queue_rename_o holds the stale head entry and must not be consumed.
  - A pop is impossible while empty.
- Full: queue_decode_ready_o = 0; decoded_v_i is ignored and the decoder must hold its data.
- count_o: count + push - pop, saturating is not required because the handshake rules make overflow and underflow impossible.
- Flush (mispredict_i = 1):
  - Next cycle: head = tail = 0 and count = 0.
  - Any push or pop presented in the flush cycle is discarded.
  - In the cycle after the flush, queue_rename_v_o = 0 and queue_decode_ready_o = 1.
  - Flush has priority over push and pop.
- Reset (reset_i = 1, synchronous): head = 0, tail = 0, count = 0.
  - Resulting outputs: queue_decode_ready_o = 1, queue_rename_v_o = 0, count_o = 0, almost_full_o = 0.
  - Storage contents are not reset.
  - Reset asserted mid-stream discards all entries, identical to a flush.
  - Reset has priority over flush.
- Output valid and data stay stable while rename_queue_ready_i = 0, unless a flush or reset occurs.

Test Plan:
- Reset, then push A=0x11 at cycle 1 with rename not ready → queue_rename_v_o=1 and queue_rename_o=0x11 at cycle 2; count_o=1.
- Push 8 entries 0x01..0x08 with rename not ready → count_o=8, queue_decode_ready_o=0, almost_full_o=1 from count 6; a 9th push of 0x09 is not accepted.
- Full queue, rename ready and decoder pushing every cycle → pops 0x01, 0x02, … in order; ready=0 during the cycle at count=8, then stream sustains one pop per cycle; no loss or duplication across pointer wrap, verified over 20 entries.
- Queue holds 5 entries and push and pop both occur while mispredict_i=1 → next cycle count_o=0, queue_rename_v_o=0; the entry pushed in the flush cycle never appears at the output.
- Empty queue with push every cycle and rename always ready → one entry out per cycle, count_o steady at 1, order preserved.
- reset_i asserted with count_o=3 and mispredict_i=1 in the same cycle → next cycle all outputs are at reset values; a push of 0x42 afterwards appears at the output one cycle later.
